router_credit_buf: RTL and testbench

- Parametrised successor to the single-port pass-through router cell.
- Adds an input flit FIFO, credit-based flow control and wormhole routing.
- The destination of each head flit is compared with ROUTER_ADDRESS. A matching packet is ejected to the local port; any other packet is forwarded to the channel output.
- Used as a whitebox NoC hop in fabric simulation and techmapping.

---
 rtl/router_credit_buf.sv | 223 ++++++++++++++++++++++
 tb/tb_router_credit_buf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_credit_buf.sv
// router_credit_buf: single-hop wormhole router cell with an input flit FIFO,
// credit-based downstream flow control and a local ejection port.
// Flit layout (index 0 is the MSB): [0] head, [1] tail, [2 +: ADDR_W] destination.
module router_credit_buf #(
  parameter int FLIT_W  = 68,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ROUTER_ADDRESS,
  input  logic [0:FLIT_W-1] CHANNEL_IN_IP,
  input  logic              CHANNEL_IN_VALID,
  output logic              FLOW_CTRL_OUT_IP,
  output logic [0:FLIT_W-1] CHANNEL_OUT_OP,
  output logic              CHANNEL_OUT_VALID,
  input  logic              FLOW_CTRL_IN_OP,
  output logic [0:FLIT_W-1] LOCAL_OUT,
  output logic              LOCAL_OUT_VALID,
  input  logic              LOCAL_OUT_READY,
  output logic              ERROR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(CREDITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_EJECT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Input FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [0:FLIT_W-1] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;

  logic [CNT_W-1:0]  r_credit;
  logic [0:FLIT_W-1] r_chan_op;
  logic              r_chan_valid;
  logic [0:FLIT_W-1] r_local;
  logic              r_local_valid;
  logic              r_fc_out;
  logic              r_error;

  logic              w_empty;
  logic              w_full;
  logic [0:FLIT_W-1] w_head_flit;
  logic              w_is_head;
  logic              w_is_tail;
  logic [ADDR_W-1:0] w_dest;
  logic              w_dest_local;
  logic              w_credit_ok;
  logic              w_local_ok;
  logic              w_push;
  logic              w_overflow;
  logic              w_pop;
  logic              w_fwd;
  logic              w_eject;
  logic              w_discard;
  logic              w_credit_over;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

  assign w_head_flit  = r_mem[r_rd_ptr[IDX_W-1:0]];
  assign w_is_head    = w_head_flit[0];
  assign w_is_tail    = w_head_flit[1];
  assign w_dest       = w_head_flit[2 +: ADDR_W];
  assign w_dest_local = (w_dest == ROUTER_ADDRESS);

  assign w_credit_ok = (r_credit != '0);
  // Local register can take a new flit if empty or drained this cycle
  assign w_local_ok  = !r_local_valid || LOCAL_OUT_READY;

  // Fullness is judged before this cycle's pop: a full FIFO drops the flit
  assign w_push     = CHANNEL_IN_VALID && !w_full;
  assign w_overflow = CHANNEL_IN_VALID && w_full;

  assign w_credit_over = FLOW_CTRL_IN_OP && !w_fwd &&
                         (r_credit == CNT_W'(CREDITS));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Routing decision and pop control; in IDLE the head flit is routed and
  // popped in the same cycle, so a single-flit packet never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fwd       = 1'b0;
    w_eject     = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (!w_is_head) begin
            w_pop     = 1'b1;
            w_discard = 1'b1;
          end else if (w_dest_local) begin
            if (w_local_ok) begin
              w_pop   = 1'b1;
              w_eject = 1'b1;
              if (!w_is_tail) w_state_nxt = S_EJECT;
            end
          end else if (w_credit_ok) begin
            w_pop = 1'b1;
            w_fwd = 1'b1;
            if (!w_is_tail) w_state_nxt = S_FWD;
          end
        end
      end
      S_FWD: begin
        if (!w_empty && w_credit_ok) begin
          w_pop = 1'b1;
          w_fwd = 1'b1;
          if (w_is_tail) w_state_nxt = S_IDLE;
        end
      end
      S_EJECT: begin
        if (!w_empty && w_local_ok) begin
          w_pop   = 1'b1;
          w_eject = 1'b1;
          if (w_is_tail) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage write; contents are don't-care until pointed to
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= CHANNEL_IN_IP;
    end
  end

  // Channel output register: valid pulses once per forward, data holds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chan_op    <= '0;
      r_chan_valid <= 1'b0;
    end else begin
      r_chan_valid <= w_fwd;
      if (w_fwd) r_chan_op <= w_head_flit;
    end
  end

  // Local ejection register held until the sink handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_local       <= '0;
      r_local_valid <= 1'b0;
    end else if (w_eject) begin
      r_local       <= w_head_flit;
      r_local_valid <= 1'b1;
    end else if (r_local_valid && LOCAL_OUT_READY) begin
      r_local_valid <= 1'b0;
    end
  end

  // Downstream credit counter; simultaneous spend and return cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit <= CNT_W'(CREDITS);
    end else if (w_fwd && !FLOW_CTRL_IN_OP) begin
      r_credit <= r_credit - CNT_W'(1);
    end else if (FLOW_CTRL_IN_OP && !w_fwd && !w_credit_over) begin
      r_credit <= r_credit + CNT_W'(1);
    end
  end

  // Credit return to upstream: one pulse per popped flit, discarded ones too
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fc_out <= 1'b0;
    end else begin
      r_fc_out <= w_pop;
    end
  end

  // Sticky protocol error: overflow, orphan body flit, or excess credit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_overflow || w_discard || w_credit_over) begin
      r_error <= 1'b1;
    end
  end

  assign FLOW_CTRL_OUT_IP  = r_fc_out;
  assign CHANNEL_OUT_OP    = r_chan_op;
  assign CHANNEL_OUT_VALID = r_chan_valid;
  assign LOCAL_OUT         = r_local;
  assign LOCAL_OUT_VALID   = r_local_valid;
  assign ERROR             = r_error;

endmodule

// File: tb/tb_router_credit_buf.sv
// Scoreboard bench for router_credit_buf: a queue-based reference model
// predicts each edge's outcome; monitors compare whatever the DUT presents.
module tb_router_credit_buf;

  localparam int FLIT_W  = 68;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  typedef logic [0:FLIT_W-1] flit_t;
  typedef struct packed {
    logic rst;
    logic fc;
    logic err;
    logic cvalid;
    logic lvalid;
  } cyc_t;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] router_addr;
  flit_t             chan_in;
  logic              chan_in_valid;
  logic              fc_out;
  flit_t             chan_out;
  logic              chan_out_valid;
  logic              fc_in;
  flit_t             local_out;
  logic              local_valid;
  logic              local_ready;
  logic              error;

  router_credit_buf #(
    .FLIT_W (FLIT_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CREDITS(CREDITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ROUTER_ADDRESS   (router_addr),
    .CHANNEL_IN_IP    (chan_in),
    .CHANNEL_IN_VALID (chan_in_valid),
    .FLOW_CTRL_OUT_IP (fc_out),
    .CHANNEL_OUT_OP   (chan_out),
    .CHANNEL_OUT_VALID(chan_out_valid),
    .FLOW_CTRL_IN_OP  (fc_in),
    .LOCAL_OUT        (local_out),
    .LOCAL_OUT_VALID  (local_valid),
    .LOCAL_OUT_READY  (local_ready),
    .ERROR            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  flit_t fwd_q[$];
  flit_t loc_q[$];
  cyc_t  cyc_q[$];

  // Reference model state: a plain queue for the buffer, an integer credit
  // count, and a note of which packet (if any) is currently being carried.
  flit_t m_fifo[$];
  int    m_credit;
  bit    m_in_pkt;
  bit    m_pkt_local;
  bit    m_loc_full;
  bit    m_err;
  int    owed;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Predict the outcome of the next rising edge for the given inputs
  function automatic void model_step(input logic v, input flit_t f, input logic fc,
                                     input logic rdy, input logic rst);
    flit_t h;
    bit    pop, fwd, ej, loc_ok, tail;
    int    sz0;
    cyc_t  c;
    if (rst) begin
      m_fifo.delete();
      loc_q.delete();
      m_credit    = CREDITS;
      m_in_pkt    = 0;
      m_pkt_local = 0;
      m_loc_full  = 0;
      m_err       = 0;
      owed        = 0;
      c = '{rst: 1'b1, fc: 1'b0, err: 1'b0, cvalid: 1'b0, lvalid: 1'b0};
      cyc_q.push_back(c);
      return;
    end
    pop = 0; fwd = 0; ej = 0;
    loc_ok = !m_loc_full || rdy;
    sz0 = m_fifo.size();
    h = '0;
    if (sz0 > 0) begin
      h = m_fifo[0];
      tail = h[1];
      if (!m_in_pkt) begin
        if (!h[0]) begin
          pop = 1; m_err = 1;
        end else if (h[2:5] == router_addr) begin
          if (loc_ok) begin pop = 1; ej = 1; m_pkt_local = 1; m_in_pkt = !tail; end
        end else if (m_credit > 0) begin
          pop = 1; fwd = 1; m_pkt_local = 0; m_in_pkt = !tail;
        end
      end else begin
        if (m_pkt_local) begin
          if (loc_ok) begin pop = 1; ej = 1; end
        end else if (m_credit > 0) begin
          pop = 1; fwd = 1;
        end
        if (pop && tail) m_in_pkt = 0;
      end
    end
    if (pop) h = m_fifo.pop_front();
    if (ej) begin
      loc_q.push_back(h);
      m_loc_full = 1;
    end else if (m_loc_full && rdy) begin
      m_loc_full = 0;
    end
    if (v) begin
      if (sz0 < DEPTH) m_fifo.push_back(f);
      else m_err = 1;
    end
    if (fwd) begin
      fwd_q.push_back(h);
      owed++;
    end
    if (fwd && !fc) m_credit--;
    else if (fc && !fwd) begin
      if (m_credit == CREDITS) m_err = 1;
      else m_credit++;
    end
    c = '{rst: 1'b0, fc: pop, err: m_err, cvalid: fwd, lvalid: m_loc_full};
    cyc_q.push_back(c);
  endfunction

  task automatic step(input logic v, input flit_t f, input logic fc,
                      input logic rdy, input logic rst);
    reset         = rst;
    chan_in_valid = v;
    chan_in       = f;
    fc_in         = fc;
    local_ready   = rdy;
    model_step(v, f, fc, rdy, rst);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  function automatic flit_t mk(input bit head, input bit tail, input logic [3:0] dest);
    flit_t f;
    f = flit_t'({$urandom(), $urandom(), $urandom()});
    f[0]   = head;
    f[1]   = tail;
    f[2:5] = dest;
    return f;
  endfunction

  // Per-cycle status and forwarded flits, sampled just after the edge
  always begin
    cyc_t c;
    @(posedge clk);
    #1;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("flow_ctrl_out", 128'(fc_out), 128'(c.fc));
      chk("error", 128'(error), 128'(c.err));
      chk("chan_valid", 128'(chan_out_valid), 128'(c.cvalid));
      chk("local_valid", 128'(local_valid), 128'(c.lvalid));
      if (c.rst) begin
        chk("chan_op_reset", 128'(chan_out), 128'(0));
        chk("local_out_reset", 128'(local_out), 128'(0));
      end
    end
    if (chan_out_valid === 1'b1) begin
      if (fwd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fwd_flit actual=%0h required=none", chan_out);
      end else begin
        chk("fwd_flit", 128'(chan_out), 128'(fwd_q.pop_front()));
      end
    end
  end

  // Ejected flits, compared when a handshake is about to complete
  always begin
    @(negedge clk);
    if (local_valid === 1'b1 && local_ready === 1'b1 && reset === 1'b0) begin
      if (loc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL eject_flit actual=%0h required=none", local_out);
      end else begin
        chk("eject_flit", 128'(local_out), 128'(loc_q.pop_front()));
      end
    end
  end

  initial begin
    flit_t pend[$];
    bit    dirty;
    int    len;
    logic [3:0] dst;
    logic  v, fc, rdy;
    flit_t f;

    reset         = 1'b1;
    router_addr   = 4'h5;
    chan_in       = '0;
    chan_in_valid = 1'b0;
    fc_in         = 1'b0;
    local_ready   = 1'b0;
    @(posedge clk);
    #2;

    // Single-flit packet to another router
    step(0, '0, 0, 0, 1);
    step(1, mk(1, 1, 4'h3), 0, 0, 0);
    idle(4, 0);

    // Local packet stalled by the sink while the FIFO overflows
    step(0, '0, 0, 0, 1);
    step(1, mk(1, 0, 4'h5), 0, 0, 0);
    step(1, mk(0, 0, 4'h5), 0, 0, 0);
    step(1, mk(0, 1, 4'h5), 0, 0, 0);
    step(1, mk(1, 1, 4'h5), 0, 0, 0);
    step(1, mk(1, 1, 4'h3), 0, 0, 0);
    step(1, mk(1, 1, 4'h3), 0, 0, 0);
    idle(10, 1);

    // Credit exhaustion then a single returned credit
    step(0, '0, 0, 1, 1);
    step(1, mk(1, 0, 4'h3), 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, mk(0, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 1, 4'h3), 0, 1, 0);
    idle(5, 1);
    step(0, '0, 1, 1, 0);
    idle(4, 1);

    // Credit return coinciding with a forward, then excess credit
    step(0, '0, 0, 1, 1);
    step(1, mk(1, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 1, 4'h3), 0, 1, 0);
    step(0, '0, 1, 1, 0);
    idle(3, 1);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    idle(2, 1);

    // Orphan body flit in IDLE
    step(0, '0, 0, 1, 1);
    step(1, mk(0, 0, 4'h3), 0, 1, 0);
    idle(4, 1);

    // Reset in the middle of a forwarded packet, then a fresh packet
    step(0, '0, 0, 1, 1);
    step(1, mk(1, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 0, 4'h3), 0, 1, 0);
    step(1, mk(0, 1, 4'h3), 0, 1, 1);
    step(1, mk(1, 1, 4'h9), 0, 1, 0);
    idle(4, 1);

    // Randomised traffic; odd phases also inject protocol errors
    for (int ph = 0; ph < 8; ph++) begin
      dirty = ph[0];
      pend.delete();
      step(0, '0, 0, 1, 1);
      for (int cyc = 0; cyc < 250; cyc++) begin
        if (pend.size() == 0) begin
          if (dirty && $urandom_range(0, 9) == 0) begin
            pend.push_back(mk(0, $urandom_range(0, 1), 4'($urandom())));
          end else begin
            len = $urandom_range(1, 4);
            dst = $urandom_range(0, 1) ? router_addr : 4'($urandom());
            for (int k = 0; k < len; k++)
              pend.push_back(mk(k == 0, k == len - 1, dst));
          end
        end
        v = (pend.size() > 0) && ($urandom_range(0, 99) < (dirty ? 80 : 50));
        f = v ? pend.pop_front() : flit_t'('0);
        if (dirty) begin
          fc = ($urandom_range(0, 99) < 30);
        end else begin
          fc = (owed > 0) && ($urandom_range(0, 99) < 50);
          if (fc) owed--;
        end
        rdy = ($urandom_range(0, 99) < 60);
        step(v, f, fc, rdy, 0);
      end
    end

    idle(20, 1);
    chk("fwd_drained", 128'(fwd_q.size()), 128'(0));
    chk("eject_drained", 128'(loc_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
